// File: rtl/alu_pkg.sv
// Shared encodings for the ALU/multiply-divide unit: operation codes and
// the sequencer states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SLTU  = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOR   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_MFHI  = 4'b1100,
        OP_MFLO  = 4'b1101,
        OP_MTHI  = 4'b1110,
        OP_MTLO  = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // mult, multu, div and divu all live in 10xx
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One-bit-per-cycle shift-add multiplier and restoring divider on operand
// magnitudes, with sign correction applied to the result of the final step.
module muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0] r_acc, r_mq, r_md, r_a;
    logic             r_div, r_neg_lo, r_neg_hi, r_div0;

    logic             w_sa, w_sb;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [WIDTH:0]   w_sub, w_add;
    logic [WIDTH-1:0] w_acc_n, w_mq_n, w_q, w_r;
    logic [2*WIDTH-1:0] w_prod;

    assign w_sa    = i_signed & i_a[WIDTH-1];
    assign w_sb    = i_signed & i_b[WIDTH-1];
    assign w_mag_a = w_sa ? -i_a : i_a;
    assign w_mag_b = w_sb ? -i_b : i_b;

    always_comb begin
        w_sub = {r_acc, r_mq[WIDTH-1]} - {1'b0, r_md};
        w_add = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_md} : '0);
        if (r_div) begin
            // top bit of the trial difference set means the divisor did not fit
            if (!w_sub[WIDTH]) begin
                w_acc_n = w_sub[WIDTH-1:0];
                w_mq_n  = {r_mq[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_n = {r_acc[WIDTH-2:0], r_mq[WIDTH-1]};
                w_mq_n  = {r_mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_n = w_add[WIDTH:1];
            w_mq_n  = {w_add[0], r_mq[WIDTH-1:1]};
        end
    end

    assign w_prod = r_neg_lo ? -{w_acc_n, w_mq_n} : {w_acc_n, w_mq_n};
    assign w_q    = r_neg_lo ? -w_mq_n  : w_mq_n;
    assign w_r    = r_neg_hi ? -w_acc_n : w_acc_n;

    always_comb begin
        if (!r_div) begin
            o_hi = w_prod[2*WIDTH-1:WIDTH];
            o_lo = w_prod[WIDTH-1:0];
        end else if (r_div0) begin
            o_hi = r_a;
            o_lo = '1;
        end else begin
            o_hi = w_r;
            o_lo = w_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mq     <= '0;
            r_md     <= '0;
            r_a      <= '0;
            r_div    <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_div0   <= 1'b0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mq     <= i_div ? w_mag_a : w_mag_b;
            r_md     <= i_div ? w_mag_b : w_mag_a;
            r_a      <= i_a;
            r_div    <= i_div;
            r_neg_lo <= w_sa ^ w_sb;
            r_neg_hi <= w_sa;
            r_div0   <= i_div & (i_b == '0);
        end else if (i_step) begin
            r_acc <= w_acc_n;
            r_mq  <= w_mq_n;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Single-cycle ALU plus HI/LO registers fed by an iterative multiply/divide
// core; the sequencer here counts WIDTH steps and commits HI/LO on the last.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    input  logic             start,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             r_busy, r_done;

    logic [WIDTH-1:0] w_add, w_sub, w_core_hi, w_core_lo;
    logic             w_launch, w_step;

    assign w_add    = a + b;
    assign w_sub    = a - b;
    assign w_launch = start && (r_state != S_RUN) && is_muldiv(f);
    assign w_step   = (r_state == S_RUN);

    always_comb begin
        case (f)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = w_add;
            OP_SUB:  y = w_sub;
            OP_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_MFHI: y = r_hi;
            OP_MFLO: y = r_lo;
            default: y = w_add;
        endcase
    end

    assign zero = (w_sub == '0);
    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_launch),
        .i_step   (w_step),
        .i_div    (f[1]),
        .i_signed (~f[0]),
        .i_a      (a),
        .i_b      (b),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hi    <= w_core_hi;
                        r_lo    <= w_core_lo;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE and DONE accept the same launches
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                    if (w_launch) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end else if (start && f == OP_MTHI) begin
                        r_hi <= a;
                    end else if (start && f == OP_MTLO) begin
                        r_lo <= a;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized self-checking bench for alu_mdu at WIDTH=32 and WIDTH=8 against
// an arithmetic reference model.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b;
    logic [3:0]  f;
    logic        start32, start8;

    logic [31:0] y32, hi32, lo32;
    logic        zero32, busy32, done32;
    logic [7:0]  y8, hi8, lo8;
    logic        zero8, busy8, done8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi32, m_lo32;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .a(a), .b(b), .f(f), .start(start32),
        .y(y32), .zero(zero32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    alu_mdu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .a(a[7:0]), .b(b[7:0]), .f(f), .start(start8),
        .y(y8), .zero(zero8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_busy(input int w); return (w == 8) ? busy8 : busy32; endfunction
    function automatic logic get_done(input int w); return (w == 8) ? done8 : done32; endfunction
    function automatic logic [31:0] get_hi(input int w); return (w == 8) ? {24'b0, hi8} : hi32; endfunction
    function automatic logic [31:0] get_lo(input int w); return (w == 8) ? {24'b0, lo8} : lo32; endfunction
    function automatic logic [31:0] get_y(input int w);  return (w == 8) ? {24'b0, y8}  : y32;  endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 8) start8 = v; else start32 = v;
    endtask

    // Reference for mult/div results, from integer arithmetic on sign- or zero-extended operands
    function automatic void model_md(input int w, input logic [3:0] op, input logic [31:0] av,
                                     input logic [31:0] bv, output logic [31:0] eh, output logic [31:0] el);
        logic [31:0] mask;
        logic [63:0] ua, ub, p, qv, rv;
        longint sa, sb;
        mask = (w == 8) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        ua = {32'b0, av & mask};
        ub = {32'b0, bv & mask};
        sa = (w == 8) ? longint'($signed(av[7:0])) : longint'($signed(av));
        sb = (w == 8) ? longint'($signed(bv[7:0])) : longint'($signed(bv));
        if (op[1] == 1'b0) begin
            p  = (op[0] == 1'b0) ? 64'(sa * sb) : ua * ub;
            el = p[31:0] & mask;
            eh = (w == 8) ? {24'b0, p[15:8]} : p[63:32];
        end else if (ub == 64'd0) begin
            el = mask;
            eh = av & mask;
        end else begin
            if (op[0] == 1'b0) begin
                qv = 64'(sa / sb);
                rv = 64'(sa % sb);
            end else begin
                qv = ua / ub;
                rv = ua % ub;
            end
            el = qv[31:0] & mask;
            eh = rv[31:0] & mask;
        end
    endfunction

    function automatic logic [31:0] model_y(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        case (op)
            4'b0000: return av & bv;
            4'b0001: return av | bv;
            4'b0110: return av - bv;
            4'b0111: return (longint'($signed(av)) < longint'($signed(bv))) ? 32'd1 : 32'd0;
            4'b0011: return (longint'({32'b0, av}) < longint'({32'b0, bv})) ? 32'd1 : 32'd0;
            4'b0100: return av ^ bv;
            4'b0101: return ~(av | bv);
            4'b1100: return m_hi32;
            4'b1101: return m_lo32;
            default: return av + bv;
        endcase
    endfunction

    // Combinational check; called at a negedge, returns at the next negedge
    task automatic alu32(input string tag, input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic st);
        f = op; a = av; b = bv; start32 = st;
        #1;
        check_eq({tag, "_y"}, y32, model_y(op, av, bv));
        check_eq({tag, "_zero"}, zero32, (av == bv));
        @(negedge clk);
        start32 = 1'b0;
        check_eq({tag, "_nobusy"}, busy32, 1'b0);
        $display("[TB] %s f=%b a=%h b=%h y=%h zero=%b", tag, op, av, bv, y32, zero32);
    endtask

    // Launch one mult/div; optionally hold start with other operands during RUN
    task automatic md(input string tag, input int w, input logic [3:0] op, input logic [31:0] av,
                      input logic [31:0] bv, input bit hold);
        logic [31:0] eh, el, gh, gl, gy;
        int n_busy, n_done, done_at;
        model_md(w, op, av, bv, eh, el);
        f = op; a = av; b = bv; set_start(w, 1'b1);
        @(negedge clk);
        n_busy = 0; n_done = 0; done_at = 0; gh = 0; gl = 0; gy = 0;
        for (int k = 1; k <= w + 4; k++) begin
            if (get_busy(w)) n_busy++;
            if (get_done(w)) begin
                n_done++;
                if (done_at == 0) begin
                    done_at = k; gh = get_hi(w); gl = get_lo(w); gy = get_y(w);
                end
            end
            set_start(w, hold && (k < w));
            f = (hold && (k < w)) ? 4'b1011 : 4'b1100;
            a = $urandom; b = $urandom;
            @(negedge clk);
        end
        check_eq({tag, "_busycycles"}, n_busy, w);
        check_eq({tag, "_done_at"}, done_at, w + 1);
        check_eq({tag, "_ndone"}, n_done, 1);
        check_eq({tag, "_hi"}, gh, eh);
        check_eq({tag, "_lo"}, gl, el);
        check_eq({tag, "_mfhi"}, gy, eh);
        if (w == 32) begin m_hi32 = eh; m_lo32 = el; end
        $display("[TB] %s W=%0d f=%b a=%h b=%h hi=%h lo=%h done_at=%0d", tag, w, op, av, bv, gh, gl, done_at);
    endtask

    task automatic mt32(input string tag, input logic [3:0] op, input logic [31:0] v);
        f = op; a = v; b = $urandom; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        if (op == 4'b1110) m_hi32 = v; else m_lo32 = v;
        check_eq({tag, "_busy"}, busy32, 1'b0);
        check_eq({tag, "_done"}, done32, 1'b0);
        f = 4'b1100; #1;
        check_eq({tag, "_mfhi"}, y32, m_hi32);
        f = 4'b1101; #1;
        check_eq({tag, "_mflo"}, y32, m_lo32);
        @(negedge clk);
        $display("[TB] %s f=%b a=%h hi=%h lo=%h", tag, op, v, hi32, lo32);
    endtask

    task automatic abort32();
        int n_done;
        f = 4'b1011; a = $urandom; b = $urandom | 32'd1; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        m_hi32 = 0; m_lo32 = 0;
        check_eq("abort_busy", busy32, 1'b0);
        check_eq("abort_hi", hi32, 32'd0);
        check_eq("abort_lo", lo32, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done32) n_done++;
            @(negedge clk);
        end
        check_eq("abort_nodone", n_done, 0);
        check_eq("abort_hi_after", hi32, 32'd0);
        $display("[TB] abort divu at RUN cycle 10 hi=%h lo=%h", hi32, lo32);
    endtask

    initial begin
        logic [3:0] op;
        logic [31:0] av, bv;
        reset = 1'b1; start32 = 1'b0; start8 = 1'b0; a = 0; b = 0; f = 0;
        m_hi32 = 0; m_lo32 = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy32, 1'b0);
        check_eq("rst_done", done32, 1'b0);
        check_eq("rst_hi", hi32, 32'd0);
        check_eq("rst_lo", lo32, 32'd0);
        check_eq("rst_hi8", hi8, 8'd0);
        reset = 1'b0;

        // First start lands on the first edge after reset release
        md("mult_neg3x4", 32, 4'b1000, 32'hFFFF_FFFD, 32'd4, 1'b0);

        alu32("sub_7_5",   4'b0110, 32'd7, 32'd5, 1'b0);
        alu32("zero_9_9",  4'b0110, 32'd9, 32'd9, 1'b0);
        alu32("slt_m1_1",  4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b1);
        alu32("sltu_m1_1", 4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b0);

        md("div_m7_2",    32, 4'b1010, 32'hFFFF_FFF9, 32'd2, 1'b0);
        md("div_min_m1",  32, 4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        md("div_by0",     32, 4'b1010, 32'h12, 32'd0, 1'b0);
        md("divu_by0",    32, 4'b1011, 32'hDEAD_BEEF, 32'd0, 1'b0);
        md("multu_hold",  32, 4'b1001, 32'd6, 32'd7, 1'b1);

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            av = $urandom; bv = ($urandom_range(0, 3) == 0) ? av : $urandom;
            alu32($sformatf("alu_rnd%0d", i), op, av, bv,
                  (op[3:2] != 2'b10 && op[3:1] != 3'b111) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            av = $urandom; bv = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i == 0) bv = bv >> 20;
            md($sformatf("md32_rnd%0d", i), 32, 4'(8 + $urandom_range(0, 3)), av, bv, 1'($urandom_range(0, 1)));
        end

        mt32("mthi_aa", 4'b1110, 32'hAA);
        mt32("mtlo_rnd", 4'b1111, $urandom);

        abort32();

        md("w8_multu_ff", 8, 4'b1001, 32'hFF, 32'hFF, 1'b0);
        md("w8_div_min",  8, 4'b1010, 32'h80, 32'hFF, 1'b0);
        md("w8_div_by0",  8, 4'b1010, 32'h85, 32'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            md($sformatf("md8_rnd%0d", i), 8, 4'(8 + $urandom_range(0, 3)),
               $urandom & 32'hFF, $urandom & 32'hFF, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
